alu_sequencer: RTL and testbench

- Command-driven sequencer that drives the 10-bit alu (opcode/op1/op2 in, res/s/g out) and consumes its results.
- Holds an 8x10-bit register file. Accepts one command at a time over a valid/ready handshake.
- Issues the ALU operation from registered operands, captures the result and flags, writes back to the register file, and returns a response over a second valid/ready handshake.
- Sits between the control/decode logic and the combinational alu.

---
 rtl/alu_sequencer.sv | 169 ++++++++++++++++
 tb/tb_alu_sequencer.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_sequencer.sv
// Command sequencer for the combinational 10-bit alu: fetches operands from an
// 8-entry register file, issues the operation, writes the result back and returns it.
module alu_sequencer #(
    parameter int              DW     = 10,
    parameter int              NREG   = 8,
    parameter int              AW     = $clog2(NREG),
    parameter int              OPW    = 5,
    parameter logic [OPW-1:0]  LDI_OP = '0
) (
    input  logic            clk,
    input  logic            rst_n,

    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic [OPW-1:0]  cmd_opcode,
    input  logic [AW-1:0]   cmd_rd,
    input  logic [AW-1:0]   cmd_rs1,
    input  logic [AW-1:0]   cmd_rs2,
    input  logic [DW-1:0]   cmd_imm,

    output logic [OPW-1:0]  alu_opcode,
    output logic [DW-1:0]   alu_op1,
    output logic [DW-1:0]   alu_op2,
    input  logic [DW-1:0]   alu_res,
    input  logic            alu_s,
    input  logic            alu_g,

    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [DW-1:0]   rsp_res,
    output logic            rsp_s,
    output logic            rsp_g,

    input  logic [AW-1:0]   dbg_addr,
    output logic [DW-1:0]   dbg_data
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic            w_accept;
    logic            w_wb_en;
    logic            w_rsp_done;

    logic [OPW-1:0]  r_alu_opcode;
    logic [DW-1:0]   r_alu_op1;
    logic [DW-1:0]   r_alu_op2;
    logic [AW-1:0]   r_rd;
    logic [DW-1:0]   r_imm;
    logic            r_flag_s;
    logic            r_flag_g;
    logic [DW-1:0]   r_rsp_res;
    logic            r_rsp_valid;

    logic            w_is_ldi;
    logic [DW-1:0]   w_wb_data;
    logic [DW-1:0]   w_rf [NREG];

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_wb_en      = 1'b0;
        w_rsp_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (cmd_valid) begin
                    w_accept     = 1'b1;
                    w_state_next = S_EXEC;
                end
            end
            S_EXEC: begin
                w_state_next = S_WB;
            end
            S_WB: begin
                w_wb_en      = 1'b1;
                w_state_next = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) begin
                    w_rsp_done   = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // The latched alu opcode doubles as the command opcode for the WB decision.
    assign w_is_ldi  = (r_alu_opcode == LDI_OP);
    assign w_wb_data = w_is_ldi ? r_imm : alu_res;

    // ---------------- Issue and response registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_alu_opcode <= '0;
            r_alu_op1    <= '0;
            r_alu_op2    <= '0;
            r_rd         <= '0;
            r_imm        <= '0;
            r_flag_s     <= 1'b0;
            r_flag_g     <= 1'b0;
            r_rsp_res    <= '0;
            r_rsp_valid  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_alu_opcode <= cmd_opcode;
                r_alu_op1    <= w_rf[cmd_rs1];
                r_alu_op2    <= w_rf[cmd_rs2];
                r_rd         <= cmd_rd;
                r_imm        <= cmd_imm;
            end
            if (w_wb_en) begin
                r_rsp_res   <= w_wb_data;
                r_rsp_valid <= 1'b1;
                if (!w_is_ldi) begin
                    r_flag_s <= alu_s;
                    r_flag_g <= alu_g;
                end
            end
            if (w_rsp_done) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // ---------------- Register file: one flop row per entry ----------------
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
        logic [DW-1:0] r_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_q <= '0;
            end else if (w_wb_en && (r_rd == AW'(gi))) begin
                r_q <= w_wb_data;
            end
        end

        assign w_rf[gi] = r_q;
    end

    // ---------------- Outputs ----------------
    assign cmd_ready  = (r_state == S_IDLE);
    assign alu_opcode = r_alu_opcode;
    assign alu_op1    = r_alu_op1;
    assign alu_op2    = r_alu_op2;
    assign rsp_valid  = r_rsp_valid;
    assign rsp_res    = r_rsp_res;
    assign rsp_s      = r_flag_s;
    assign rsp_g      = r_flag_g;
    assign dbg_data   = w_rf[dbg_addr];

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: directed scenarios plus random commands against a
// register-file/flag model; a small behavioural alu closes the loop.
module tb_alu_sequencer;

    localparam logic [4:0] LDI = 5'b00000;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [4:0]  cmd_opcode;
    logic [2:0]  cmd_rd;
    logic [2:0]  cmd_rs1;
    logic [2:0]  cmd_rs2;
    logic [9:0]  cmd_imm;
    logic [4:0]  alu_opcode;
    logic [9:0]  alu_op1;
    logic [9:0]  alu_op2;
    logic [9:0]  alu_res;
    logic        alu_s;
    logic        alu_g;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [9:0]  rsp_res;
    logic        rsp_s;
    logic        rsp_g;
    logic [2:0]  dbg_addr;
    logic [9:0]  dbg_data;

    int n_vec;
    int n_err;

    // Reference state: register file, sticky flags, and the command in flight.
    logic [9:0]  m_rf [8];
    logic        m_s;
    logic        m_g;
    logic [2:0]  p_rd;
    logic [9:0]  p_res;
    logic        p_s;
    logic        p_g;

    alu_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_opcode (cmd_opcode),
        .cmd_rd     (cmd_rd),
        .cmd_rs1    (cmd_rs1),
        .cmd_rs2    (cmd_rs2),
        .cmd_imm    (cmd_imm),
        .alu_opcode (alu_opcode),
        .alu_op1    (alu_op1),
        .alu_op2    (alu_op2),
        .alu_res    (alu_res),
        .alu_s      (alu_s),
        .alu_g      (alu_g),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_res    (rsp_res),
        .rsp_s      (rsp_s),
        .rsp_g      (rsp_g),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural stand-in for the team alu: returns {s, g, res}.
    function automatic logic [11:0] alu_f(input logic [4:0] op, input logic [9:0] a, input logic [9:0] b);
        logic [9:0] r;
        r = a | ~b;
        case (op)
            5'b00101: r = a + b;
            5'b00111: r = a - b;
            5'b01001: r = a & b;
            5'b01011: r = a ^ b;
            5'b10010: r = {a[8:0], 1'b0} ^ b;
            default:  r = a | ~b;
        endcase
        return {r[9], (a > b), r};
    endfunction

    always_comb begin
        {alu_s, alu_g, alu_res} = alu_f(alu_opcode, alu_op1, alu_op2);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic summary_and_finish();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 8; i++) m_rf[i] = '0;
        m_s = 1'b0;
        m_g = 1'b0;
    endtask

    task automatic check_rf_zero(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check(tag, dbg_data, 10'd0);
        end
    endtask

    task automatic drive_cmd(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic [9:0] imm);
        cmd_opcode = op;
        cmd_rd     = rd;
        cmd_rs1    = rs1;
        cmd_rs2    = rs2;
        cmd_imm    = imm;
        cmd_valid  = 1'b1;
    endtask

    // Present a command, wait for acceptance, check the issued alu operands.
    task automatic start_cmd(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                             input logic [2:0] rs2, input logic [9:0] imm, output int waits);
        logic [11:0] a;
        logic [9:0]  e1;
        logic [9:0]  e2;
        drive_cmd(op, rd, rs1, rs2, imm);
        waits = 0;
        while (!cmd_ready && waits < 20) begin
            tick();
            waits++;
        end
        if (!cmd_ready) begin
            check("accept_timeout", 32'd0, 32'd1);
            summary_and_finish();
        end
        e1 = m_rf[rs1];
        e2 = m_rf[rs2];
        tick();
        cmd_valid = 1'b0;
        check("alu_opcode", alu_opcode, op);
        check("alu_op1", alu_op1, e1);
        check("alu_op2", alu_op2, e2);
        check("busy_cmd_ready", cmd_ready, 1'b0);
        p_rd = rd;
        if (op == LDI) begin
            p_res = imm;
            p_s   = m_s;
            p_g   = m_g;
        end else begin
            a     = alu_f(op, e1, e2);
            p_res = a[9:0];
            p_s   = a[11];
            p_g   = a[10];
        end
    endtask

    // Wait for the response, optionally stall it, complete the handshake, check writeback.
    task automatic finish_cmd(input int hold);
        int lat;
        lat = 1;
        rsp_ready = (hold == 0);
        while (!rsp_valid && lat < 12) begin
            tick();
            lat++;
        end
        if (!rsp_valid) begin
            check("rsp_timeout", 32'd0, 32'd1);
            summary_and_finish();
        end
        check("rsp_latency", lat, 3);
        check("rsp_res", rsp_res, p_res);
        check("rsp_s", rsp_s, p_s);
        check("rsp_g", rsp_g, p_g);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("hold_rsp_valid", rsp_valid, 1'b1);
            check("hold_rsp_res", rsp_res, p_res);
            check("hold_cmd_ready", cmd_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("post_rsp_valid", rsp_valid, 1'b0);
        check("post_cmd_ready", cmd_ready, 1'b1);
        m_rf[p_rd] = p_res;
        m_s = p_s;
        m_g = p_g;
        dbg_addr = p_rd;
        #1;
        check("dbg_rd", dbg_data, m_rf[p_rd]);
    endtask

    task automatic run_cmd(input logic [4:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                           input logic [2:0] rs2, input logic [9:0] imm, input int hold);
        int w;
        start_cmd(op, rd, rs1, rs2, imm, w);
        finish_cmd(hold);
    endtask

    task automatic load_prefix();
        run_cmd(LDI, 3'd1, 3'd0, 3'd0, 10'd2, 0);
        run_cmd(LDI, 3'd2, 3'd0, 3'd0, 10'd4, 0);
    endtask

    logic [4:0] ops [5];
    logic [9:0] first_res;

    initial begin
        int w;
        logic [4:0] op;
        ops[0] = 5'b00101; ops[1] = 5'b00111; ops[2] = 5'b01001;
        ops[3] = 5'b01011; ops[4] = 5'b10010;
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_opcode = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0; cmd_imm = '0;
        rsp_ready = 1'b0;
        dbg_addr = '0;
        model_reset();

        // Reset state
        repeat (3) tick();
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_res", rsp_res, 10'd0);
        check("rst_alu_opcode", alu_opcode, 5'd0);
        check("rst_alu_op1", alu_op1, 10'd0);
        check("rst_alu_op2", alu_op2, 10'd0);
        rst_n = 1'b1;
        tick();
        check("rel_cmd_ready", cmd_ready, 1'b1);
        check("rel_rsp_valid", rsp_valid, 1'b0);
        check_rf_zero("rel_rf_zero");

        // Loads and every listed opcode on r1=2, r2=4
        load_prefix();
        check("ldi_flag_s", rsp_s, 1'b0);
        check("ldi_flag_g", rsp_g, 1'b0);
        for (int k = 0; k < 5; k++) begin
            run_cmd(ops[k], 3'd3, 3'd1, 3'd2, 10'h3ff, 0);
        end

        // Backpressure with a second command waiting the whole time
        start_cmd(5'b00101, 3'd4, 3'd1, 3'd2, 10'd0, w);
        drive_cmd(5'b00111, 3'd5, 3'd4, 3'd1, 10'd0);
        finish_cmd(5);
        start_cmd(5'b00111, 3'd5, 3'd4, 3'd1, 10'd0, w);
        check("bp_accept_delay", w, 0);
        finish_cmd(0);

        // Read-after-write through the register file
        load_prefix();
        start_cmd(5'b00101, 3'd1, 3'd1, 3'd2, 10'd0, w);
        check("hz_first_op1", alu_op1, 10'd2);
        finish_cmd(0);
        first_res = m_rf[1];
        start_cmd(5'b00101, 3'd3, 3'd1, 3'd2, 10'd0, w);
        check("hz_second_op1", alu_op1, first_res);
        finish_cmd(0);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 6))
                0:       op = LDI;
                6:       op = 5'($urandom_range(1, 31));
                default: op = ops[$urandom_range(0, 4)];
            endcase
            run_cmd(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                    3'($urandom_range(0, 7)), 10'($urandom_range(0, 1023)),
                    int'($urandom_range(0, 2)));
        end

        // Reset while the command is in EXEC
        load_prefix();
        start_cmd(5'b00101, 3'd5, 3'd1, 3'd2, 10'd0, w);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_rst_rsp_valid", rsp_valid, 1'b0);
        check("mid_rst_alu_op1", alu_op1, 10'd0);
        check_rf_zero("mid_rst_rf_zero");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("mid_rel_cmd_ready", cmd_ready, 1'b1);
        check("mid_rel_rsp_valid", rsp_valid, 1'b0);
        check("mid_rel_flag_s", rsp_s, 1'b0);
        run_cmd(LDI, 3'd6, 3'd0, 3'd0, 10'h155, 0);
        run_cmd(5'b01011, 3'd7, 3'd6, 3'd5, 10'd0, 1);

        summary_and_finish();
    end

endmodule
